// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types and constants for the melody player
// Note dividers are half-periods at a 100 MHz clock.
package music_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam int unsigned DIV_REST = 0;
   localparam int unsigned DUR_END  = 0;

   localparam int unsigned DIV_C4 = 191113;
   localparam int unsigned DIV_D4 = 170262;
   localparam int unsigned DIV_E4 = 151686;
   localparam int unsigned DIV_F4 = 143173;
   localparam int unsigned DIV_G4 = 127551;
   localparam int unsigned DIV_A4 = 113636;
   localparam int unsigned DIV_B4 = 101238;
   localparam int unsigned DIV_C5 = 95557;
   localparam int unsigned DIV_C6 = 47778;

   localparam int unsigned DEF_TICK_CYC = 1_000_000;
   localparam int unsigned DEF_GAP_CYC  = 50_000;

endpackage

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - half-period counter driving the square-wave flip-flop
// A zero divider holds the tone low; load clears both counter and tone.
module tone_divider #(
   parameter int unsigned DIV_W = 20
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tone_o
);

   logic [DIV_W-1:0] phase_q;
   logic             tone_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         phase_q <= '0;
         tone_q  <= 1'b0;
      end else if (load_i) begin
         phase_q <= '0;
         tone_q  <= 1'b0;
      end else if (en_i && (div_i != '0)) begin
         if (phase_q == div_i - DIV_W'(1)) begin
            phase_q <= '0;
            tone_q  <= ~tone_q;
         end else begin
            phase_q <= phase_q + DIV_W'(1);
         end
      end
   end

   assign tone_o = tone_q;

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - note-table melody player with rests, gaps and looping
// Holds the note RAM, duration/gap counters and the sequencing FSM.
module tone_sequencer
   import music_pkg::*;
#(
   parameter int unsigned NUM_NOTES = 16,
   parameter int unsigned DIV_W     = 20,
   parameter int unsigned DUR_W     = 8,
   parameter int unsigned TICK_CYC  = DEF_TICK_CYC,
   parameter int unsigned GAP_CYC   = DEF_GAP_CYC,
   parameter int unsigned AMP_W     = 23,
   localparam int unsigned IDX_W    = $clog2(NUM_NOTES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             loop_en,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [DIV_W-1:0] wr_div,
   input  logic [DUR_W-1:0] wr_dur,
   output logic [AMP_W-1:0] sound,
   output logic             busy,
   output logic [IDX_W-1:0] note_idx,
   output logic             done
);

   localparam int unsigned TICK_W = $clog2(TICK_CYC + 1);
   localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);

   logic [DIV_W-1:0] div_mem [NUM_NOTES];
   logic [DUR_W-1:0] dur_mem [NUM_NOTES];

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  note_idx_q, idx_d, load_idx;
   logic [DIV_W-1:0]  cur_div_q, cur_div_d;
   logic [DUR_W-1:0]  cur_dur_q, cur_dur_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              busy_q, done_q, done_d;
   logic              do_load, end_song, tone;

   // Table is not reset; a read in the same cycle as a write returns old data.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         div_mem[wr_addr] <= wr_div;
         dur_mem[wr_addr] <= wr_dur;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = note_idx_q;
      cur_div_d = cur_div_q;
      cur_dur_d = cur_dur_q;
      tick_d    = tick_q;
      dur_d     = dur_q;
      gap_d     = gap_q;
      done_d    = 1'b0;
      do_load   = 1'b0;
      end_song  = 1'b0;
      load_idx  = note_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               do_load  = 1'b1;
               load_idx = '0;
            end
         end
         ST_PLAY: begin
            if (tick_q == TICK_W'(TICK_CYC - 1)) begin
               tick_d = '0;
               if (dur_q + DUR_W'(1) == cur_dur_q) begin
                  state_d = ST_GAP;
                  gap_d   = '0;
               end else begin
                  dur_d = dur_q + DUR_W'(1);
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(GAP_CYC - 1)) begin
               if (note_idx_q == IDX_W'(NUM_NOTES - 1)) begin
                  end_song = 1'b1;
               end else begin
                  do_load  = 1'b1;
                  load_idx = note_idx_q + IDX_W'(1);
               end
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (do_load && (dur_mem[load_idx] == '0)) begin
         do_load  = 1'b0;
         end_song = 1'b1;
      end
      // Looping onto an empty entry 0 would spin forever, so it ends the song.
      if (end_song) begin
         if (loop_en && (dur_mem[IDX_W'(0)] != '0)) begin
            do_load  = 1'b1;
            load_idx = '0;
         end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end
      if (do_load) begin
         state_d   = ST_PLAY;
         idx_d     = load_idx;
         cur_div_d = div_mem[load_idx];
         cur_dur_d = dur_mem[load_idx];
         tick_d    = '0;
         dur_d     = '0;
      end
      if (stop) begin
         state_d = ST_IDLE;
         idx_d   = note_idx_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         note_idx_q <= '0;
         cur_div_q  <= '0;
         cur_dur_q  <= '0;
         tick_q     <= '0;
         dur_q      <= '0;
         gap_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         note_idx_q <= idx_d;
         cur_div_q  <= cur_div_d;
         cur_dur_q  <= cur_dur_d;
         tick_q     <= tick_d;
         dur_q      <= dur_d;
         gap_q      <= gap_d;
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= done_d;
      end
   end

   // The tone runs only while PLAY persists; any entry to or exit from PLAY clears it.
   tone_divider #(
      .DIV_W(DIV_W)
   ) u_tone_divider (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .en_i   (state_q == ST_PLAY),
      .load_i (!((state_q == ST_PLAY) && (state_d == ST_PLAY))),
      .div_i  (cur_div_q),
      .tone_o (tone)
   );

   assign sound    = {AMP_W{tone}};
   assign busy     = busy_q;
   assign note_idx = note_idx_q;
   assign done     = done_q;

endmodule
